// File: rtl/pulse_scheduler_if.sv
// Request/width inputs and shared pulse outputs of the pulse scheduler.
// The scheduler takes the slave side.
interface pulse_scheduler_if #(
    parameter int N_REQ   = 4,
    parameter int WIDTH_W = 4
);
    logic [N_REQ-1:0]         req;
    logic [N_REQ*WIDTH_W-1:0] width_cfg;
    logic                     signal;
    logic [N_REQ-1:0]         grant;
    logic [N_REQ-1:0]         done;
    logic                     busy;
    logic [2:0]               count;

    modport master (
        output req, width_cfg,
        input  signal, grant, done, busy, count
    );

    modport slave (
        input  req, width_cfg,
        output signal, grant, done, busy, count
    );
endinterface

// File: rtl/pulse_scheduler.sv
// Round-robin arbiter driving one shared pulse line with per-requester
// widths, a forced low gap and a wrapping completed-pulse counter.
module pulse_scheduler #(
    parameter int N_REQ   = 4,
    parameter int WIDTH_W = 4,
    parameter int GAP     = 2
) (
    input logic          clock,
    input logic          reset,
    pulse_scheduler_if.slave bus
);
    localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_PULSE,
        S_GAP
    } state_t;

    state_t             state;
    logic [IW-1:0]      rr;
    logic [IW-1:0]      pick;
    logic               found;
    logic [WIDTH_W-1:0] w_sel;
    logic [WIDTH_W-1:0] cnt;
    logic [GW-1:0]      gap_cnt;
    logic               start;
    int                 idx;

    always_comb begin
        pick  = '0;
        found = 1'b0;
        idx   = 0;
        for (int k = 1; k <= N_REQ; k++) begin
            idx = (int'(rr) + k) % N_REQ;
            if (!found && bus.req[idx]) begin
                found = 1'b1;
                pick  = IW'(idx);
            end
        end
    end

    assign w_sel = bus.width_cfg[pick*WIDTH_W +: WIDTH_W];

    // The last gap edge doubles as the first idle edge, so the line
    // stays low exactly GAP cycles (one cycle when GAP is zero).
    assign start = found &&
                   (state == S_IDLE ||
                    (state == S_GAP && gap_cnt == '0));

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state      <= S_IDLE;
            rr         <= IW'(N_REQ - 1);
            cnt        <= '0;
            gap_cnt    <= '0;
            bus.signal <= 1'b0;
            bus.grant  <= '0;
            bus.done   <= '0;
            bus.busy   <= 1'b0;
            bus.count  <= '0;
        end else begin
            bus.done <= '0;
            if (start) begin
                state      <= S_PULSE;
                rr         <= pick;
                bus.signal <= 1'b1;
                bus.busy   <= 1'b1;
                bus.grant  <= {{(N_REQ-1){1'b0}}, 1'b1} << pick;
                cnt        <= (w_sel == '0) ? '0 : w_sel - 1'b1;
            end else begin
                unique case (state)
                    S_PULSE: begin
                        if (cnt == '0) begin
                            bus.signal <= 1'b0;
                            bus.grant  <= '0;
                            bus.done   <= bus.grant;
                            bus.count  <= bus.count + 3'd1;
                            if (GAP > 0) begin
                                state   <= S_GAP;
                                gap_cnt <= GW'(GAP - 1);
                            end else begin
                                state    <= S_IDLE;
                                bus.busy <= 1'b0;
                            end
                        end else begin
                            cnt <= cnt - 1'b1;
                        end
                    end
                    S_GAP: begin
                        if (gap_cnt == '0) begin
                            state    <= S_IDLE;
                            bus.busy <= 1'b0;
                        end else begin
                            gap_cnt <= gap_cnt - 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_pulse_scheduler.sv
// Scoreboard bench for pulse_scheduler: stimulus queues expected pulses,
// a negedge monitor measures each pulse and checks it against the queue.
module tb_pulse_scheduler;
    localparam int N = 4;
    localparam int W = 4;
    localparam int G = 2;

    typedef struct {
        int idx;
        int width;
        int cnt;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    pulse_scheduler_if #(.N_REQ(N), .WIDTH_W(W)) bus ();

    pulse_scheduler #(.N_REQ(N), .WIDTH_W(W), .GAP(G)) dut (
        .clock(clk),
        .reset(rst_n),
        .bus  (bus)
    );

    exp_t sb[$];
    exp_t e;
    int   checks = 0;
    int   passed = 0;
    int   exp_count = 0;
    logic mon_en = 1'b0;

    task automatic chk(string name, int act, int req);
        checks++;
        if (act == req) passed++;
        else $display("FAIL %s: got %0d expected %0d", name, act, req);
    endtask

    // Monitor: measures pulse length and low time, checks at each fall.
    initial begin
        bit prev;
        bit had;
        int hi_len;
        int lo_len;
        int cur_g;
        prev = 0; had = 0; hi_len = 0; lo_len = 0; cur_g = 0;
        forever begin
            @(negedge clk);
            if (!mon_en) begin
                prev = 0; had = 0; lo_len = 0;
            end else begin
                chk("grant_onehot0", int'($onehot0(bus.grant)), 1);
                if (bus.signal) begin
                    if (!prev) begin
                        if (had) chk("gap_low_ok", (lo_len >= G) ? 1 : 0, 1);
                        cur_g  = int'(bus.grant);
                        hi_len = 1;
                    end else begin
                        hi_len++;
                    end
                end else if (prev) begin
                    if (sb.size() == 0) begin
                        chk("unexpected_pulse", sb.size(), 1);
                    end else begin
                        e = sb.pop_front();
                        chk("pulse_grant", cur_g, 1 << e.idx);
                        chk("pulse_width", hi_len, e.width);
                        chk("done_strobe", int'(bus.done), 1 << e.idx);
                        chk("pulse_count", int'(bus.count), e.cnt);
                    end
                    had = 1;
                    lo_len = 1;
                end else begin
                    lo_len++;
                end
                prev = bus.signal;
            end
        end
    end

    task automatic set_w(int i, int w);
        bus.width_cfg[i*W +: W] = W'(w);
    endtask

    task automatic push(int i, int w, int c);
        exp_t x;
        x.idx = i;
        x.width = (w == 0) ? 1 : w;
        x.cnt = c;
        sb.push_back(x);
    endtask

    task automatic wait_idle();
        int n = 0;
        while (bus.busy && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        chk("idle_timeout", int'(bus.busy), 0);
    endtask

    task automatic pulse_one(int i, int w, int hold, int neww);
        set_w(i, w);
        exp_count = (exp_count + 1) % 8;
        push(i, w, exp_count);
        bus.req = N'(1 << i);
        @(posedge clk); #1;
        repeat (hold) begin
            @(posedge clk); #1;
        end
        set_w(i, neww);
        bus.req = '0;
        wait_idle();
    endtask

    task automatic do_reset();
        mon_en = 1'b0;
        bus.req = '0;
        rst_n = 1'b0;
        repeat (2) begin
            @(posedge clk); #1;
        end
        rst_n = 1'b1;
        exp_count = 0;
        mon_en = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0;
        bus.req = '0;
        bus.width_cfg = '0;
        #12;
        chk("rst_signal", int'(bus.signal), 0);
        chk("rst_grant", int'(bus.grant), 0);
        chk("rst_done", int'(bus.done), 0);
        chk("rst_busy", int'(bus.busy), 0);
        chk("rst_count", int'(bus.count), 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        mon_en = 1'b1;

        // single width-3 pulse, busy timing around the gap
        set_w(0, 3);
        exp_count = 1;
        push(0, 3, 1);
        bus.req = 4'b0001;
        @(posedge clk); #1;
        bus.req = '0;
        repeat (4) @(posedge clk);
        #1 chk("busy_in_gap", int'(bus.busy), 1);
        @(posedge clk); #1;
        chk("busy_after_gap", int'(bus.busy), 0);
        chk("count_after_1", int'(bus.count), 1);
        wait_idle();

        // all requesters held, width 1: order 0,1,2,3,0
        do_reset();
        for (int i = 0; i < N; i++) set_w(i, 1);
        push(0, 1, 1);
        push(1, 1, 2);
        push(2, 1, 3);
        push(3, 1, 4);
        push(0, 1, 5);
        exp_count = 5;
        bus.req = 4'b1111;
        repeat (13) @(posedge clk);
        #1 bus.req = '0;
        wait_idle();
        chk("count_rr", int'(bus.count), 5);

        // width boundaries, mid-pulse width change, early req drop
        pulse_one(0, 0, 0, 0);
        pulse_one(1, 15, 0, 15);
        pulse_one(2, 5, 1, 9);
        pulse_one(2, 6, 1, 6);
        chk("count_wrap", int'(bus.count), 1);

        // asynchronous reset during cycle 3 of a width-8 pulse
        mon_en = 1'b0;
        set_w(2, 8);
        bus.req = 4'b0100;
        repeat (2) begin
            @(posedge clk); #1;
        end
        @(posedge clk); #3;
        chk("pre_rst_signal", int'(bus.signal), 1);
        rst_n = 1'b0;
        #1;
        chk("arst_signal", int'(bus.signal), 0);
        chk("arst_grant", int'(bus.grant), 0);
        chk("arst_busy", int'(bus.busy), 0);
        chk("arst_done", int'(bus.done), 0);
        chk("arst_count", int'(bus.count), 0);
        bus.req = 4'b1010;
        set_w(1, 2);
        repeat (2) begin
            @(posedge clk); #1;
        end
        rst_n = 1'b1;
        mon_en = 1'b1;
        exp_count = 1;
        push(1, 2, 1);
        @(posedge clk); #1;
        bus.req = '0;
        wait_idle();

        // nine back-to-back pulses: count 1..7,0,1
        do_reset();
        set_w(0, 1);
        for (int k = 1; k <= 9; k++) push(0, 1, k % 8);
        exp_count = 1;
        bus.req = 4'b0001;
        repeat (25) @(posedge clk);
        #1 bus.req = '0;
        wait_idle();

        repeat (4) @(posedge clk);
        chk("sb_empty", sb.size(), 0);
        chk("final_count", int'(bus.count), exp_count);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
